// File: rtl/pipe_hazard_ctrl_if.sv
// ============================================================================
// Module      : pipe_hazard_ctrl_if
// Description : Hazard-controller bundle: pipeline status in, stage enables,
//               flushes and multi-cycle status out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipe_hazard_ctrl_if;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       idex_mem_re;
    logic [4:0] idex_rd;
    logic       exmem_branch_taken;
    logic       ex_mc_req;
    logic       mem_wait;

    logic       pc_we;
    logic       if_id_we;
    logic       id_ex_we;
    logic       ex_mem_we;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       ex_mem_flush;
    logic       mc_start;
    logic       mc_done;
    logic       busy;

    // Pipeline side: reports hazard sources, obeys the enables.
    modport master (
        output id_rs1, id_rs2, idex_mem_re, idex_rd,
               exmem_branch_taken, ex_mc_req, mem_wait,
        input  pc_we, if_id_we, id_ex_we, ex_mem_we,
               if_id_flush, id_ex_flush, ex_mem_flush,
               mc_start, mc_done, busy
    );

    // Controller side.
    modport slave (
        input  id_rs1, id_rs2, idex_mem_re, idex_rd,
               exmem_branch_taken, ex_mc_req, mem_wait,
        output pc_we, if_id_we, id_ex_we, ex_mem_we,
               if_id_flush, id_ex_flush, ex_mem_flush,
               mc_start, mc_done, busy
    );
endinterface

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : 5-stage pipeline sequencer: load-use bubbles, branch flushes,
//               multi-cycle EX freeze and memory-wait stall. Optional event
//               counters enabled by macro PIPE_HAZARD_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl #(
    parameter int MC_CYCLES = 32,
    parameter int CNT_W     = 6
) (
    input  wire logic         clk,
    input  wire logic         reset,
`ifdef PIPE_HAZARD_STATS_EN
    output logic [31:0]       stat_stall_cnt,
    output logic [31:0]       stat_flush_cnt,
    output logic [31:0]       stat_mc_cnt,
`endif
    pipe_hazard_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_MC_BUSY = 2'd1,
        S_MC_LAST = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_MC_LOAD = CNT_W'(MC_CYCLES - 2);
    // A two-cycle op has no busy phase: start is followed directly by last.
    localparam state_t c_MC_FIRST = (MC_CYCLES == 2) ? S_MC_LAST : S_MC_BUSY;

    state_t           r_state;
    state_t           w_nxt_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_nxt_cnt;

    logic w_load_use;
    logic w_pc_we;
    logic w_if_id_we;
    logic w_id_ex_we;
    logic w_ex_mem_we;
    logic w_if_id_flush;
    logic w_id_ex_flush;
    logic w_ex_mem_flush;
    logic w_mc_start;
    logic w_mc_done;
    logic w_busy;
    logic w_ev_stall;
    logic w_ev_flush;

    assign w_load_use = bus.idex_mem_re && (bus.idex_rd != 5'd0) &&
                        ((bus.idex_rd == bus.id_rs1) || (bus.idex_rd == bus.id_rs2));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
        end
    end

    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_cnt      = r_cnt;
        w_pc_we        = 1'b1;
        w_if_id_we     = 1'b1;
        w_id_ex_we     = 1'b1;
        w_ex_mem_we    = 1'b1;
        w_if_id_flush  = 1'b0;
        w_id_ex_flush  = 1'b0;
        w_ex_mem_flush = 1'b0;
        w_mc_start     = 1'b0;
        w_mc_done      = 1'b0;
        w_ev_stall     = 1'b0;
        w_ev_flush     = 1'b0;
        w_busy         = (r_state != S_RUN);

        if (bus.mem_wait) begin
            w_pc_we     = 1'b0;
            w_if_id_we  = 1'b0;
            w_id_ex_we  = 1'b0;
            w_ex_mem_we = 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (bus.exmem_branch_taken) begin
                        w_if_id_flush  = 1'b1;
                        w_id_ex_flush  = 1'b1;
                        w_ex_mem_flush = 1'b1;
                        w_ev_flush     = 1'b1;
                    end else if (bus.ex_mc_req) begin
                        w_mc_start     = 1'b1;
                        w_pc_we        = 1'b0;
                        w_if_id_we     = 1'b0;
                        w_id_ex_we     = 1'b0;
                        w_ex_mem_flush = 1'b1;
                        w_nxt_cnt      = c_MC_LOAD;
                        w_nxt_state    = c_MC_FIRST;
                    end else if (w_load_use) begin
                        w_pc_we       = 1'b0;
                        w_if_id_we    = 1'b0;
                        w_id_ex_flush = 1'b1;
                        w_ev_stall    = 1'b1;
                    end
                end
                S_MC_BUSY: begin
                    w_pc_we        = 1'b0;
                    w_if_id_we     = 1'b0;
                    w_id_ex_we     = 1'b0;
                    w_ex_mem_flush = 1'b1;
                    w_nxt_cnt      = r_cnt - 1'b1;
                    if (r_cnt <= CNT_W'(1)) begin
                        w_nxt_state = S_MC_LAST;
                    end
                end
                S_MC_LAST: begin
                    w_mc_done   = 1'b1;
                    w_nxt_state = S_RUN;
                end
                default: begin
                    w_nxt_state = S_RUN;
                end
            endcase
        end

        // Reset overrides everything so the pipe holds bubbles immediately.
        if (reset) begin
            w_pc_we        = 1'b0;
            w_if_id_we     = 1'b0;
            w_id_ex_we     = 1'b0;
            w_ex_mem_we    = 1'b0;
            w_if_id_flush  = 1'b1;
            w_id_ex_flush  = 1'b1;
            w_ex_mem_flush = 1'b1;
            w_mc_start     = 1'b0;
            w_mc_done      = 1'b0;
            w_busy         = 1'b0;
            w_ev_stall     = 1'b0;
            w_ev_flush     = 1'b0;
        end
    end

    assign bus.pc_we        = w_pc_we;
    assign bus.if_id_we     = w_if_id_we;
    assign bus.id_ex_we     = w_id_ex_we;
    assign bus.ex_mem_we    = w_ex_mem_we;
    assign bus.if_id_flush  = w_if_id_flush;
    assign bus.id_ex_flush  = w_id_ex_flush;
    assign bus.ex_mem_flush = w_ex_mem_flush;
    assign bus.mc_start     = w_mc_start;
    assign bus.mc_done      = w_mc_done;
    assign bus.busy         = w_busy;

`ifdef PIPE_HAZARD_STATS_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;
    logic [31:0] r_mc_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_mc_cnt    <= '0;
        end else begin
            if (w_ev_stall) r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_ev_flush) r_flush_cnt <= r_flush_cnt + 32'd1;
            if (w_mc_start) r_mc_cnt    <= r_mc_cnt + 32'd1;
        end
    end

    assign stat_stall_cnt = r_stall_cnt;
    assign stat_flush_cnt = r_flush_cnt;
    assign stat_mc_cnt    = r_mc_cnt;
`else
    logic w_unused_ev;
    assign w_unused_ev = w_ev_stall ^ w_ev_flush;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Self-checking bench for pipe_hazard_ctrl (MC_CYCLES=4) with a
//               cycle-count reference model; stats checked when enabled.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;
    localparam int MC = 4;

    logic clk = 1'b0;
    logic reset_r;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if ifc();

`ifdef PIPE_HAZARD_STATS_EN
    logic [31:0] s_stall, s_flush, s_mc;
`endif

    pipe_hazard_ctrl #(.MC_CYCLES(MC), .CNT_W(6)) dut (
        .clk            (clk),
        .reset          (reset_r),
`ifdef PIPE_HAZARD_STATS_EN
        .stat_stall_cnt (s_stall),
        .stat_flush_cnt (s_flush),
        .stat_mc_cnt    (s_mc),
`endif
        .bus            (ifc)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Model: EX-occupancy cycles still owed to a multi-cycle op (0 = none).
    int m_left = 0;
    int m_stall = 0, m_flush = 0, m_mc = 0;

    // {pc,ifid,idex,exmem we | ifid,idex,exmem flush | start,done,busy}
    localparam logic [9:0] V_RESET = 10'b0000111000;
    localparam logic [9:0] V_RUN   = 10'b1111000000;
    localparam logic [9:0] V_BR    = 10'b1111111000;
    localparam logic [9:0] V_START = 10'b0001001100;
    localparam logic [9:0] V_BUSY  = 10'b0001001001;
    localparam logic [9:0] V_LAST  = 10'b1111000011;
    localparam logic [9:0] V_LU    = 10'b0011010000;

    wire [9:0] w_act = {ifc.pc_we, ifc.if_id_we, ifc.id_ex_we, ifc.ex_mem_we,
                        ifc.if_id_flush, ifc.id_ex_flush, ifc.ex_mem_flush,
                        ifc.mc_start, ifc.mc_done, ifc.busy};

    function automatic logic is_lu();
        return ifc.idex_mem_re && (ifc.idex_rd != 5'd0) &&
               (ifc.idex_rd == ifc.id_rs1 || ifc.idex_rd == ifc.id_rs2);
    endfunction

    function automatic logic [9:0] exp_out();
        if (reset_r)                return V_RESET;
        if (ifc.mem_wait)           return {9'b0, (m_left > 0)};
        if (m_left == 1)            return V_LAST;
        if (m_left > 1)             return V_BUSY;
        if (ifc.exmem_branch_taken) return V_BR;
        if (ifc.ex_mc_req)          return V_START;
        if (is_lu())                return V_LU;
        return V_RUN;
    endfunction

    task automatic set_reset(input logic v);
        reset_r = v;
        if (v) begin
            m_left = 0; m_stall = 0; m_flush = 0; m_mc = 0;
        end
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic mre, input logic [4:0] rd,
                         input logic br, input logic mcr, input logic mw);
        ifc.id_rs1 = rs1; ifc.id_rs2 = rs2; ifc.idex_mem_re = mre;
        ifc.idex_rd = rd; ifc.exmem_branch_taken = br;
        ifc.ex_mc_req = mcr; ifc.mem_wait = mw;
    endtask

    // Clock edge plus model update from the inputs that were present at it.
    task automatic advance();
        @(posedge clk);
        if (reset_r) begin
            m_left = 0; m_stall = 0; m_flush = 0; m_mc = 0;
        end else if (!ifc.mem_wait) begin
            if (m_left > 0) m_left--;
            else if (ifc.exmem_branch_taken) m_flush++;
            else if (ifc.ex_mc_req) begin m_left = MC - 1; m_mc++; end
            else if (is_lu()) m_stall++;
        end
        #1;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        set_reset(1'b1);
        #2;
        n_chk++;
        if (w_act !== V_RESET) begin
            n_fail++; $display("FAIL reset_hold actual=%b expected=%b", w_act, V_RESET);
        end
        advance(); advance();
        set_reset(1'b0);
        #1;
        n_chk++;
        if (w_act !== V_RUN) begin
            n_fail++; $display("FAIL reset_release actual=%b expected=%b", w_act, V_RUN);
        end
        set_reset(1'b1);
        #1;
        n_chk++;
        if (w_act !== V_RESET) begin
            n_fail++; $display("FAIL reset_midcycle actual=%b expected=%b", w_act, V_RESET);
        end
        set_reset(1'b0);
        advance();
        n_chk++;
        if (w_act !== V_RUN) begin
            n_fail++; $display("FAIL reset_after actual=%b expected=%b", w_act, V_RUN);
        end
    endtask

    task automatic test_load_use();
        logic [9:0] exp_v [4] = '{V_LU, V_RUN, V_RUN, V_LU};
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: drive(5'd3, 5'd5, 1'b1, 5'd5, 0, 0, 0);
                1: drive(5'd3, 5'd5, 1'b0, 5'd5, 0, 0, 0);
                2: drive(5'd0, 5'd0, 1'b1, 5'd0, 0, 0, 0);
                default: drive(5'd9, 5'd1, 1'b1, 5'd9, 0, 0, 0);
            endcase
            @(negedge clk);
            n_chk++;
            if (w_act !== exp_v[i] || w_act !== exp_out()) begin
                n_fail++;
                $display("FAIL load_use step=%0d actual=%b expected=%b", i, w_act, exp_v[i]);
            end
            advance();
        end
    endtask

    task automatic test_multicycle();
        logic [9:0] exp_v [5] = '{V_START, V_BUSY, V_BUSY, V_LAST, V_RUN};
        for (int i = 0; i < 5; i++) begin
            drive(5'd1, 5'd2, 1'b0, 5'd3, 1'b0, (i < 4), 1'b0);
            @(negedge clk);
            n_chk++;
            if (w_act !== exp_v[i] || w_act !== exp_out()) begin
                n_fail++;
                $display("FAIL multicycle cyc=%0d actual=%b expected=%b", i, w_act, exp_v[i]);
            end
            advance();
        end
    endtask

    task automatic test_branch_priority();
        logic [9:0] exp_v [2] = '{V_BR, V_RUN};
        for (int i = 0; i < 2; i++) begin
            if (i == 0) drive(5'd7, 5'd2, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0);
            else        drive(5'd1, 5'd2, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            n_chk++;
            if (w_act !== exp_v[i] || w_act !== exp_out()) begin
                n_fail++;
                $display("FAIL branch_prio cyc=%0d actual=%b expected=%b", i, w_act, exp_v[i]);
            end
            advance();
        end
    endtask

    task automatic test_mem_wait();
        int done_at = -1;
        for (int i = 0; i < 12; i++) begin
            drive(5'd1, 5'd2, 1'b0, 5'd3, 1'b0, (i == 0), (i >= 2 && i <= 4));
            @(negedge clk);
            n_chk++;
            if (w_act !== exp_out() ||
                (i >= 2 && i <= 4 && w_act !== 10'b0000000001)) begin
                n_fail++;
                $display("FAIL mem_wait cyc=%0d actual=%b expected=%b", i, w_act, exp_out());
            end
            if (ifc.mc_done === 1'b1 && done_at < 0) done_at = i;
            advance();
        end
        n_chk++;
        if (done_at != (MC - 1) + 3) begin
            n_fail++;
            $display("FAIL mem_wait_done_cycle actual=%0d expected=%0d", done_at, MC + 2);
        end
    endtask

    task automatic test_reset_abort();
        int dones = 0;
        drive(0, 0, 0, 0, 0, 1'b1, 0);
        advance();
        drive(0, 0, 0, 0, 0, 1'b0, 0);
        #2;
        set_reset(1'b1);
        #1;
        n_chk++;
        if (w_act !== V_RESET) begin
            n_fail++; $display("FAIL abort_reset actual=%b expected=%b", w_act, V_RESET);
        end
        advance();
        set_reset(1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ifc.mc_done === 1'b1 || ifc.busy === 1'b1) dones++;
            advance();
        end
        n_chk++;
        if (dones != 0) begin
            n_fail++; $display("FAIL abort_no_done actual=%0d expected=0", dones);
        end
    endtask

    task automatic test_random();
        logic hold_rst = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (hold_rst) begin set_reset(1'b0); hold_rst = 1'b0; end
            else if ($urandom_range(0, 99) == 0) begin set_reset(1'b1); hold_rst = 1'b1; end
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 99) < 40), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 15),
                  ($urandom_range(0, 99) < 15));
            @(negedge clk);
            n_chk++;
            if (w_act !== exp_out()) begin
                n_fail++;
                $display("FAIL random cyc=%0d actual=%b expected=%b", i, w_act, exp_out());
            end
`ifdef PIPE_HAZARD_STATS_EN
            n_chk++;
            if (s_stall !== 32'(m_stall) || s_flush !== 32'(m_flush) || s_mc !== 32'(m_mc)) begin
                n_fail++;
                $display("FAIL random_stats cyc=%0d actual=%0d/%0d/%0d expected=%0d/%0d/%0d",
                         i, s_stall, s_flush, s_mc, m_stall, m_flush, m_mc);
            end
`endif
            advance();
        end
        set_reset(1'b0);
    endtask

`ifdef PIPE_HAZARD_STATS_EN
    task automatic test_stats();
        drive(0, 0, 0, 0, 0, 0, 0);
        set_reset(1'b1);
        advance();
        set_reset(1'b0);
        for (int i = 0; i < 10; i++) begin
            case (i)
                0, 2:    drive(5'd4, 5'd1, 1'b1, 5'd4, 0, 0, 0);
                4:       drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 0, 0);
                5:       drive(5'd0, 5'd0, 1'b0, 5'd0, 0, 1'b1, 0);
                7:       drive(5'd4, 5'd1, 1'b1, 5'd4, 0, 0, 1'b1);
                default: drive(5'd0, 5'd0, 1'b0, 5'd0, 0, 0, 0);
            endcase
            advance();
        end
        @(negedge clk);
        n_chk++;
        if (s_stall !== 32'd2 || s_flush !== 32'd1 || s_mc !== 32'd1) begin
            n_fail++;
            $display("FAIL stats actual=%0d/%0d/%0d expected=2/1/1", s_stall, s_flush, s_mc);
        end
        advance();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_use();
        test_multicycle();
        test_branch_priority();
        test_mem_wait();
        test_reset_abort();
`ifdef PIPE_HAZARD_STATS_EN
        test_stats();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage core.
- Drives write-enables and flushes of the PC, IF/ID, ID/EX and EX/MEM registers.
- Inserts load-use bubbles and flushes on taken branches resolved at the EX/MEM boundary.
- Freezes the EX stage for a fixed number of cycles while a multi-cycle EX operation runs, and stalls the whole pipe on data-memory wait.

Parameters:
MC_CYCLES, 32, cycles a multi-cycle EX op occupies EX (min 2)
CNT_W, 6, width of the multi-cycle down-counter; must satisfy 2^CNT_W > MC_CYCLES

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
id_rs1  input  5  rs1 address of the instruction in ID
id_rs2  input  5  rs2 address of the instruction in ID
idex_mem_re  input  1  mem_re of the instruction in EX (ID/EX output)
idex_rd  input  5  rd address of the instruction in EX
exmem_branch_taken  input  1  branch_instruction_out AND branch_out at the EX/MEM output
ex_mc_req  input  1  instruction in EX is a multi-cycle op
mem_wait  input  1  data memory not ready
pc_we  output  1  PC register write enable
if_id_we  output  1  IF/ID write enable
id_ex_we  output  1  ID/EX write enable
ex_mem_we  output  1  EX/MEM write enable
if_id_flush  output  1  load NOP into IF/ID on next edge
id_ex_flush  output  1  load bubble into ID/EX on next edge
ex_mem_flush  output  1  load bubble into EX/MEM on next edge
mc_start  output  1  one-cycle pulse: multi-cycle op begins
mc_done  output  1  one-cycle pulse: last cycle of multi-cycle op
busy  output  1  FSM not in RUN

Behaviour:
- FSM states: RUN, MC_BUSY, MC_LAST. State and counter are registered; all outputs are combinational from state, counter and inputs (Mealy), zero added latency.
- Reset asserted (async): state=RUN, counter=0. While reset is high, outputs are forced to: pc_we=0, if_id_we=0, id_ex_we=0, ex_mem_we=0, all flushes=1, mc_start=0, mc_done=0, busy=0.
- Default (RUN, no event): all *_we=1, all flushes=0.
- Priority, highest first: mem_wait > exmem_branch_taken > multi-cycle > load-use.
- mem_wait=1, any state: all *_we=0, all flushes=0, state and counter frozen, pulses suppressed.
- Branch taken, RUN only: if_id_flush=1, id_ex_flush=1, ex_mem_flush=1, all *_we=1. An ex_mc_req or load-use condition in the same cycle is ignored, because the instruction in EX is squashed.
- Multi-cycle, RUN with ex_mc_req=1:
  - mc_start=1, pc_we=0, if_id_we=0, id_ex_we=0, ex_mem_flush=1.
  - Counter loads MC_CYCLES-2; next state is MC_BUSY.
- MC_BUSY:
  - pc_we=0, if_id_we=0, id_ex_we=0, ex_mem_flush=1.
  - Counter decrements each non-wait cycle; when it is 0, next state is MC_LAST.
- MC_LAST:
  - mc_done=1, all *_we=1, flushes=0, so the EX result is captured into EX/MEM.
  - Next state is RUN.
  - ex_mc_req is ignored in this cycle.
- Total EX occupancy = MC_CYCLES cycles (1 start + MC_CYCLES-2 busy + 1 last).
- Load-use, RUN, no higher-priority event: condition is idex_mem_re=1 AND idex_rd!=0 AND (idex_rd==id_rs1 OR idex_rd==id_rs2).
  - Response: pc_we=0, if_id_we=0, id_ex_flush=1, others default.
  - Exactly one bubble; no state change.
- rd=x0 never triggers a load-use stall.
- busy=1 in MC_BUSY and MC_LAST.
- Reset mid-operation aborts the multi-cycle op immediately; no mc_done is issued.

Optional Feature:
- Macro PIPE_HAZARD_STATS_EN.
- When defined, adds three outputs, each 32 bits: stat_stall_cnt, stat_flush_cnt, stat_mc_cnt.
  - stat_stall_cnt increments on each load-use bubble.
  - stat_flush_cnt increments on each branch flush.
  - stat_mc_cnt increments on each mc_start.
- All counters wrap modulo 2^32, hold during mem_wait, and clear on reset.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
1. Reset pulse mid-cycle -> outputs immediately pc_we=0, all flushes=1. After release: pc_we=1, if_id_we=1, flushes=0, busy=0.
2. idex_mem_re=1, idex_rd=5, id_rs2=5 -> for one cycle pc_we=0, if_id_we=0, id_ex_flush=1. Same stimulus with idex_rd=0 -> no stall.
3. ex_mc_req=1 with MC_CYCLES=4 -> mc_start at cycle 0, id_ex_we=0 for cycles 0-2, mc_done and ex_mem_we=1 at cycle 3, busy=1 in cycles 1-3, RUN in cycle 4.
4. exmem_branch_taken=1 together with ex_mc_req=1 and a load-use condition -> all three flushes=1, mc_start=0, pc_we=1.
5. mem_wait=1 for 3 cycles in the middle of MC_BUSY (MC_CYCLES=4) -> all we=0 and flushes=0 during the wait; mc_done is delayed by exactly 3 cycles.
6. With PIPE_HAZARD_STATS_EN defined: 2 load-use bubbles, 1 branch flush and 1 mc op -> stat_stall_cnt=2, stat_flush_cnt=1, stat_mc_cnt=1.
